// File: rtl/ext_cmd_arbiter.sv
// Arbitrates the shared EXT_BUS command channel between N command-handler clients.
// The first strobed word picks an owner by command range; later words are routed to that owner until the frame drops.
module ext_cmd_arbiter #(
    parameter int              N       = 4,
    parameter logic [16*N-1:0] CMD_LO  = {16'hF3, 16'hF8, 16'hF0, 16'hE0},
    parameter logic [16*N-1:0] CMD_HI  = {16'hF7, 16'hFF, 16'hF2, 16'hEF},
    parameter int              TIMEOUT = 4096
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            io_enable,
    input  logic            io_strobe,
    input  logic [15:0]     io_din,
    output logic [15:0]     io_dout,
    output logic            dout_en,
    output logic [N-1:0]    cl_sel,
    output logic [4:0]      cl_idx,
    input  logic [16*N-1:0] cl_rdata,
    output logic            cl_wr,
    output logic [4:0]      cl_widx,
    output logic [15:0]     cl_wdata,
    output logic            cl_done,
    output logic            cl_abort,
    output logic            busy,
    output logic [7:0]      miss_cnt,
    output logic [7:0]      tmo_cnt
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWNED, UNCLAIMED, LOCKED} state_t;

    state_t          state, state_next;
    logic [OW-1:0]   owner, hit_idx, rd_idx;
    logic [4:0]      idx;
    logic [WW-1:0]   wdog;
    logic            hit;
    logic [15:0]     sel_rdata;
    logic            claim, miss, word, expire, finish, wdog_clr, wdog_inc;

    // Scanning downwards lets the lowest matching client overwrite the others.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (io_din >= CMD_LO[16*i +: 16] && io_din <= CMD_HI[16*i +: 16]) begin
                hit     = 1'b1;
                hit_idx = OW'(i);
            end
        end
    end

    assign rd_idx = (state == IDLE) ? hit_idx : owner;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (OW'(i) == rd_idx) sel_rdata = cl_rdata[16*i +: 16];
        end
    end

    always_comb begin
        state_next = state;
        claim      = 1'b0;
        miss       = 1'b0;
        word       = 1'b0;
        expire     = 1'b0;
        finish     = 1'b0;
        wdog_clr   = 1'b0;
        wdog_inc   = 1'b0;
        if (!io_enable) begin
            // A strobe coinciding with the frame drop is discarded.
            state_next = IDLE;
            finish     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (io_strobe) begin
                        claim      = hit;
                        miss       = !hit;
                        state_next = hit ? OWNED : UNCLAIMED;
                    end
                end
                OWNED, UNCLAIMED: begin
                    if (io_strobe) begin
                        word     = (state == OWNED);
                        wdog_clr = 1'b1;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        expire     = 1'b1;
                        state_next = LOCKED;
                    end else begin
                        wdog_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= '0;
            idx      <= '0;
            wdog     <= '0;
            io_dout  <= '0;
            dout_en  <= 1'b0;
            cl_sel   <= '0;
            cl_wr    <= 1'b0;
            cl_widx  <= '0;
            cl_wdata <= '0;
            cl_done  <= 1'b0;
            cl_abort <= 1'b0;
            miss_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            cl_wr    <= 1'b0;
            cl_done  <= 1'b0;
            cl_abort <= 1'b0;
            if (finish) begin
                owner   <= '0;
                idx     <= '0;
                wdog    <= '0;
                io_dout <= '0;
                dout_en <= 1'b0;
                cl_sel  <= '0;
                cl_done <= (state == OWNED);
            end
            if (claim) begin
                owner    <= hit_idx;
                cl_sel   <= N'(1) << hit_idx;
                dout_en  <= 1'b1;
                io_dout  <= sel_rdata;
                cl_wr    <= 1'b1;
                cl_widx  <= idx;
                cl_wdata <= io_din;
                idx      <= 5'd1;
                wdog     <= '0;
            end
            if (miss) begin
                dout_en  <= 1'b0;
                io_dout  <= '0;
                miss_cnt <= miss_cnt + 8'd1;
                wdog     <= '0;
            end
            if (word) begin
                io_dout  <= sel_rdata;
                cl_wr    <= 1'b1;
                cl_widx  <= idx;
                cl_wdata <= io_din;
                if (idx != 5'd31) idx <= idx + 5'd1;
            end
            if (wdog_clr) wdog <= '0;
            if (wdog_inc) wdog <= wdog + WW'(1);
            if (expire) begin
                wdog     <= '0;
                io_dout  <= '0;
                dout_en  <= 1'b0;
                cl_sel   <= '0;
                tmo_cnt  <= tmo_cnt + 8'd1;
                cl_abort <= (state == OWNED);
            end
        end
    end

    assign cl_idx = idx;
    assign busy   = (state != IDLE);

endmodule
